// File: rtl/immgen_pkg.sv
// Shared format codes and RV base opcodes for the immediate generator.
package immgen_pkg;
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
endpackage

// File: rtl/immgen_decode.sv
// Combinational immediate/format/target decode for one instruction.
module immgen_decode
  import immgen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic [XLEN-1:0] target
);
  logic [63:0] imm64;
  logic        is_sh;
  logic        sh6;

  assign is_sh = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);
  // Only the full-width OP-IMM shift carries a 6-bit shamt; OP-IMM-32 is always 5-bit.
  assign sh6   = (XLEN == 64) && (instr[6:0] == OP_IMM) && instr[25];

  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_IMM:           fmt = is_sh ? FMT_SHAMT : FMT_I;
      OP_IMM32:         if (XLEN == 64) fmt = is_sh ? FMT_SHAMT : FMT_I;
      OP_STORE:         fmt = FMT_S;
      OP_BRANCH:        fmt = FMT_B;
      OP_LUI, OP_AUIPC: fmt = FMT_U;
      OP_JAL:           fmt = FMT_J;
      default:          fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm64 = '0;
    case (fmt)
      FMT_I:     imm64 = {{52{instr[31]}}, instr[31:20]};
      FMT_S:     imm64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:     imm64 = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:     imm64 = {{32{instr[31]}}, instr[31:12], 12'b0};
      FMT_J:     imm64 = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_SHAMT: imm64 = {58'b0, sh6, instr[24:20]};
      default:   imm64 = '0;
    endcase
  end

  assign imm    = imm64[XLEN-1:0];
  assign target = pc + imm;
endmodule

// File: rtl/immgen_pipe.sv
// Registered immediate generator with a one-entry skid buffer; in_ready comes straight from a flop.
module immgen_pipe
  import immgen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic [XLEN-1:0] target;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          dec, main_q, skid_q;
  logic            main_vld, skid_vld, rdy_q;
  logic [XLEN-1:0] d_imm, d_target;
  fmt_t            d_fmt;
  logic            accept, drain;

  immgen_decode #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .imm   (d_imm),
    .fmt   (d_fmt),
    .target(d_target)
  );

  assign dec    = '{imm: d_imm, fmt: d_fmt, target: d_target, instr: in_instr, pc: in_pc};
  assign accept = in_valid && rdy_q;
  assign drain  = main_vld && out_ready;

  // rdy_q tracks the next-state of "SKID empty" so an accept can never land on a full SKID.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (!main_vld || drain) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
        rdy_q    <= 1'b1;
      end else begin
        main_vld <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
      rdy_q    <= 1'b0;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = main_vld;
  assign out_imm    = main_q.imm;
  assign out_fmt    = main_q.fmt;
  assign out_target = main_q.target;
  assign out_instr  = main_q.instr;
  assign out_pc     = main_q.pc;
endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: XLEN=64 and XLEN=32 instances share stimulus and a FIFO scoreboard.
module tb_immgen_pipe;
  logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        rdy64, ov64, rdy32, ov32;
  logic [63:0] imm64, tgt64, pc64;
  logic [31:0] imm32, tgt32, pc32, oi64, oi32;
  logic [2:0]  fmt64, fmt32;

  immgen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64), .out_instr(oi64), .out_pc(pc64));

  immgen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32), .out_instr(oi32), .out_pc(pc32));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } txn_t;
  txn_t q[$];

  function automatic logic [2:0] ref_fmt(logic [31:0] i, int xl);
    logic sh;
    sh = (i[14:12] == 3'd1) || (i[14:12] == 3'd5);
    case (i[6:0])
      7'b0000011, 7'b1100111: return 3'd1;
      7'b0010011:             return sh ? 3'd6 : 3'd1;
      7'b0011011:             return (xl != 64) ? 3'd0 : (sh ? 3'd6 : 3'd1);
      7'b0100011:             return 3'd2;
      7'b1100011:             return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      7'b1101111:             return 3'd5;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(logic [31:0] i, int xl);
    longint v;
    case (ref_fmt(i, xl))
      3'd1: v = longint'($signed(i[31:20]));
      3'd2: v = longint'($signed({i[31:25], i[11:7]}));
      3'd3: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd4: v = longint'($signed({i[31:12], 12'h000}));
      3'd5: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd6: v = (xl == 64 && i[6:0] == 7'b0010011) ? longint'(i[25:20]) : longint'(i[24:20]);
      default: v = 0;
    endcase
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare on the falling edge, then apply the handshake that the next rising edge performs.
  always @(negedge clk) begin
    int n;
    logic [63:0] e;
    n = q.size();
    if (chk_en && !reset) begin
      chk("sb_valid64", 64'(ov64), 64'(n > 0));
      chk("sb_ready64", 64'(rdy64), 64'(n < 2));
      chk("sb_valid32", 64'(ov32), 64'(n > 0));
      chk("sb_ready32", 64'(rdy32), 64'(n < 2));
      if (n > 0) begin
        e = ref_imm(q[0].instr, 64);
        chk("sb_imm64",   imm64, e);
        chk("sb_fmt64",   64'(fmt64), 64'(ref_fmt(q[0].instr, 64)));
        chk("sb_tgt64",   tgt64, q[0].pc + e);
        chk("sb_instr64", 64'(oi64), 64'(q[0].instr));
        chk("sb_pc64",    pc64, q[0].pc);
        e = ref_imm(q[0].instr, 32);
        chk("sb_imm32",   64'(imm32), e);
        chk("sb_fmt32",   64'(fmt32), 64'(ref_fmt(q[0].instr, 32)));
        chk("sb_tgt32",   64'(tgt32), (q[0].pc + e) & 64'hFFFF_FFFF);
        chk("sb_instr32", 64'(oi32), 64'(q[0].instr));
        chk("sb_pc32",    64'(pc32), q[0].pc & 64'hFFFF_FFFF);
      end
    end
    if (reset || flush) q.delete();
    else begin
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [63:0] p);
    in_instr = i; in_pc = p; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  logic [6:0] ops [12];
  logic [31:0] r;

  initial begin
    ops = '{7'b0000011, 7'b1100111, 7'b0010011, 7'b0010011, 7'b0011011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1111111};
    step(); step();
    chk_en = 1'b1;
    chk("rst_valid", 64'(ov64), 64'd0);
    chk("rst_ready", 64'(rdy64), 64'd1);
    chk("rst_imm",   imm64, 64'd0);
    chk("rst_fmt",   64'(fmt64), 64'd0);
    chk("rst_tgt",   tgt64, 64'd0);
    chk("rst_instr", 64'(oi64), 64'd0);
    chk("rst_pc",    pc64, 64'd0);
    reset = 1'b0;
    step();

    send(32'hFFF00093, 64'h0);
    chk("addi_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_fmt", 64'(fmt64), 64'd1);
    step();
    send(32'hFE000EE3, 64'h1000);
    chk("beq_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_fmt", 64'(fmt64), 64'd3);
    chk("beq_tgt", tgt64, 64'hFFC);
    step();
    send(32'h800000B7, 64'h0);
    chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", 64'(imm32), 64'h8000_0000);
    step();
    send(32'h0010006F, 64'h0);
    chk("jal_imm", imm64, 64'h800);
    chk("jal_fmt", 64'(fmt64), 64'd5);
    step();
    send(32'h03F09093, 64'h0);
    chk("slli_imm", imm64, 64'd63);
    chk("slli_fmt", 64'(fmt64), 64'd6);
    step();
    send(32'h43F0D093, 64'h0);
    chk("srai_imm", imm64, 64'd63);
    step();

    // Stall: A, B, C back-to-back with out_ready low for three edges.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100093; step();
    in_instr = 32'h00200113; step();
    chk("stall_ready_lo", 64'(rdy64), 64'd0);
    in_instr = 32'h00300193; step();
    chk("stall_ready_hold", 64'(rdy64), 64'd0);
    chk("stall_head_A", 64'(oi64), 64'h00100093);
    out_ready = 1'b1; step();
    chk("order_B", 64'(oi64), 64'h00200113);
    chk("ready_back", 64'(rdy64), 64'd1);
    step();
    chk("order_C", 64'(oi64), 64'h00300193);
    chk("order_C_vld", 64'(ov64), 64'd1);
    in_valid = 1'b0; step();
    chk("drained", 64'(ov64), 64'd0);

    // Flush with both entries full, then a fresh instruction.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100093; step();
    in_instr = 32'h00200113; step();
    in_instr = 32'h00300193; flush = 1'b1; step();
    flush = 1'b0;
    chk("flush_valid", 64'(ov64), 64'd0);
    chk("flush_ready", 64'(rdy64), 64'd1);
    in_instr = 32'h12345037; out_ready = 1'b1; step();
    chk("post_flush_vld", 64'(ov64), 64'd1);
    chk("post_flush_instr", 64'(oi64), 64'h12345037);
    in_valid = 1'b0; step();
    chk("post_flush_empty", 64'(ov64), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      reset     = (c == 1500);
      in_instr  = {r[31:7], ops[$urandom_range(0, 11)]};
      in_pc     = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
